skew_buffer: RTL and testbench
==============================

# skew_buffer

Input-staging block for the systolic-array matrix multiplier. It takes one row of ARRAY_SIZE signed operands per cycle and delays lane i by exactly i clock cycles. The result is the diagonal wavefront the processing-element grid expects. One instance sits on each operand edge of the array, between the operand source and the first row or column of PEs.

## Interface
Parameters:
- DATA_WIDTH, default 8: bit width of each signed operand.
- ARRAY_SIZE, default 8: number of lanes, equal to the systolic array dimension; must be at least 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all delay stages.
- enable  input  1  advance strobe; when 1, all delay chains shift by one stage on the rising edge.
- data_in  input  signed [DATA_WIDTH-1:0] x ARRAY_SIZE (unpacked [ARRAY_SIZE-1:0])  one operand per lane.
- data_out  output  signed [DATA_WIDTH-1:0] x ARRAY_SIZE (unpacked [ARRAY_SIZE-1:0])  skewed operands, lane i delayed i cycles.

## Operation
- Lane i contains a shift chain of exactly i registers of DATA_WIDTH bits. Total storage is ARRAY_SIZE*(ARRAY_SIZE-1)/2 words.
- Lane 0 has no registers: data_out[0] = data_in[0] combinationally, regardless of enable or reset.
- Lane i ≥ 1, when enable=1 at the rising edge:
  - stage 0 ← data_in[i];
  - stage k ← stage k-1 for 1 ≤ k < i.
- Lane i ≥ 1 output: data_out[i] = stage i-1, which is the final register of that lane.
- When enable=0 at the rising edge, every stage holds its value, so outputs for lanes ≥ 1 are frozen.
- Values pass through unmodified. There is no arithmetic, sign change or saturation, and the full signed DATA_WIDTH value is preserved.
- The block has no handshake, no ready/valid and no FSM. Downstream logic must track validity by counting enabled cycles.

## Timing
- Reset (rst=0): all stages clear to 0 immediately, without waiting for a clock edge.
  - Reset value of data_out[i] for i ≥ 1 is 0.
  - data_out[0] continues to follow data_in[0].
- Reset has priority over enable. Asserting rst mid-stream discards all in-flight data.
- After rst deasserts, the first rising edge with enable=1 loads stage 0 of every lane ≥ 1.
- Latency for lane i is exactly i enabled rising edges from the sample edge to appearance on data_out[i].
- Lane 0 latency is 0 cycles.
- Disabled cycles stretch latency one-for-one. Data is neither lost nor duplicated across enable gaps.
- Streaming back-to-back: a new row can be accepted on every enabled edge, giving a throughput of one row per cycle.
- Drain: after the last valid row, ARRAY_SIZE-1 further enabled edges flush it completely.
  - data_in should then be driven with 0 so zeros shift in behind it.
- Degenerate ARRAY_SIZE=1: the block is pure pass-through with no registers.

## Test plan
- Reset check: hold rst=0 with data_in[i]=i → data_out[1..7]=0 and data_out[0]=data_in[0]. Release rst and hold enable=0 for 3 edges → outputs unchanged.
- Staircase fill (DATA_WIDTH=8, ARRAY_SIZE=8): after reset, drive data_in[i]=i and enable=1 held. Required response:
  - after edge k, data_out[i]=i for all i ≤ k, and 0 for i > k;
  - after 7 edges, data_out = {0,1,2,3,4,5,6,7}.
- Streaming skew: feed rows r=1..4 with data_in[i]=10*r+i on consecutive enabled edges, then zeros → data_out[i] shows 10*r+i exactly i cycles after row r was applied.
- Enable stall: start a stream, deassert enable for 2 cycles after the 3rd row, then resume → outputs freeze during the stall, and the subsequent sequence is the unstalled sequence shifted by 2 cycles.
- Signed extremes: inject -128 and 127 on lane 7 → both appear bit-exact on data_out[7] after 7 enabled edges.
- Reset mid-operation: assert rst after 4 enabled edges of the staircase → data_out[1..7] become 0 asynchronously, and after release refilling restarts from the first enabled edge.

Source files
------------

// File: rtl/skew_buffer.sv
// Input-staging skew buffer for the systolic array: lane i is delayed by exactly i
// enabled clock edges, turning a parallel operand row into a diagonal wavefront.
module skew_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_SIZE = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] data_in  [ARRAY_SIZE-1:0],
    output logic signed [DATA_WIDTH-1:0] data_out [ARRAY_SIZE-1:0]
);

    genvar gi;
    generate
        for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
            if (gi == 0) begin : g_pass
                // Lane 0 carries no delay and bypasses reset entirely.
                assign data_out[0] = data_in[0];
            end else begin : g_chain
                logic signed [DATA_WIDTH-1:0] stage_r [0:gi-1];

                // Lane delay chain: stage 0 samples the input, later stages shift down.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        for (int k = 0; k < gi; k++) begin
                            stage_r[k] <= '0;
                        end
                    end else if (enable) begin
                        stage_r[0] <= data_in[gi];
                        for (int k = 1; k < gi; k++) begin
                            stage_r[k] <= stage_r[k-1];
                        end
                    end
                end

                assign data_out[gi] = stage_r[gi-1];
            end
        end
    endgenerate

endmodule

// File: tb/tb_skew_buffer.sv
// Randomized self-checking bench for skew_buffer; the reference model keeps the
// history of rows accepted since reset and reads lane i from the row i edges back.
module tb_skew_buffer;
    localparam int DW = 8;
    localparam int AS = 8;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic enable = 1'b0;
    logic signed [DW-1:0] din  [AS-1:0];
    logic signed [DW-1:0] dout [AS-1:0];
    logic signed [DW-1:0] snap [AS-1:0];
    logic [DW*AS-1:0] hist [$];
    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    skew_buffer #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS)) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .data_in (din),
        .data_out(dout)
    );

    // Reference: lane i shows the row accepted i enabled edges ago, or 0 if none since reset.
    function automatic logic signed [DW-1:0] exp_lane(int i);
        logic [DW*AS-1:0] row;
        if (i == 0) return din[0];
        if (hist.size() < i) return '0;
        row = hist[hist.size() - i];
        return row[i*DW +: DW];
    endfunction

    // One clock: record the row if the edge is an enabled, non-reset edge; end at negedge.
    task automatic cycle();
        logic [DW*AS-1:0] row;
        @(posedge clk);
        if (rst && enable) begin
            for (int i = 0; i < AS; i++) row[i*DW +: DW] = din[i];
            hist.push_back(row);
            if (hist.size() > AS) void'(hist.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int i = 0; i < AS; i++) din[i] = DW'(i);
        rst = 1'b0;
        hist.delete();
        #1;
        for (int i = 0; i < AS; i++) begin
            nvec++;
            if (dout[i] !== ((i == 0) ? din[0] : 8'sd0)) begin
                nfail++;
                $display("FAIL reset lane %0d: got %0d expected %0d", i, dout[i], (i == 0) ? din[0] : 8'sd0);
            end
        end
        din[0] = -8'sd5;
        #1;
        nvec++;
        if (dout[0] !== -8'sd5) begin
            nfail++;
            $display("FAIL reset_lane0_pass: got %0d expected -5", dout[0]);
        end
        din[0] = 8'sd0;
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            for (int i = 0; i < AS; i++) begin
                nvec++;
                if (dout[i] !== ((i == 0) ? 8'sd0 : 8'sd0) || dout[i] !== exp_lane(i)) begin
                    nfail++;
                    $display("FAIL reset_hold lane %0d: got %0d expected %0d", i, dout[i], exp_lane(i));
                end
            end
        end
    endtask

    task automatic test_staircase(string name);
        enable = 1'b1;
        for (int i = 0; i < AS; i++) din[i] = DW'(i);
        for (int k = 1; k < AS; k++) begin
            cycle();
            for (int i = 0; i < AS; i++) begin
                nvec++;
                if (dout[i] !== ((i <= k) ? DW'(i) : 8'sd0)) begin
                    nfail++;
                    $display("FAIL %s edge %0d lane %0d: got %0d expected %0d", name, k, i, dout[i], (i <= k) ? i : 0);
                end
            end
        end
    endtask

    task automatic test_streaming();
        enable = 1'b1;
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < AS; i++) din[i] = (t < 4) ? DW'(10 * (t + 1) + i) : 8'sd0;
            cycle();
            for (int i = 0; i < AS; i++) begin
                nvec++;
                if (dout[i] !== exp_lane(i)) begin
                    nfail++;
                    $display("FAIL streaming t %0d lane %0d: got %0d expected %0d", t, i, dout[i], exp_lane(i));
                end
            end
        end
    endtask

    task automatic test_stall();
        for (int t = 0; t < 14; t++) begin
            enable = !(t == 3 || t == 4);
            for (int i = 0; i < AS; i++) din[i] = DW'($urandom);
            snap = dout;
            cycle();
            for (int i = 0; i < AS; i++) begin
                nvec++;
                if (dout[i] !== exp_lane(i)) begin
                    nfail++;
                    $display("FAIL stall t %0d lane %0d: got %0d expected %0d", t, i, dout[i], exp_lane(i));
                end
                if (!enable && i > 0) begin
                    nvec++;
                    if (dout[i] !== snap[i]) begin
                        nfail++;
                        $display("FAIL stall_freeze t %0d lane %0d: got %0d expected %0d", t, i, dout[i], snap[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_signed();
        enable = 1'b1;
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < AS; i++) din[i] = (t < 2) ? DW'($urandom) : 8'sd0;
            if (t == 0) din[AS-1] = 8'sh80;
            if (t == 1) din[AS-1] = 8'sh7f;
            cycle();
            for (int i = 0; i < AS; i++) begin
                nvec++;
                if (dout[i] !== exp_lane(i)) begin
                    nfail++;
                    $display("FAIL signed t %0d lane %0d: got %0d expected %0d", t, i, dout[i], exp_lane(i));
                end
            end
            if (t == 6 || t == 7) begin
                nvec++;
                if (dout[AS-1] !== ((t == 6) ? 8'sh80 : 8'sh7f)) begin
                    nfail++;
                    $display("FAIL signed_extreme t %0d: got %0d expected %0d", t, dout[AS-1], (t == 6) ? -128 : 127);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < AS; i++) din[i] = DW'(i);
        for (int k = 0; k < 4; k++) cycle();
        #2;
        rst = 1'b0;
        hist.delete();
        #1;
        for (int i = 0; i < AS; i++) begin
            nvec++;
            if (dout[i] !== ((i == 0) ? din[0] : 8'sd0)) begin
                nfail++;
                $display("FAIL reset_mid_async lane %0d: got %0d expected %0d", i, dout[i], (i == 0) ? din[0] : 8'sd0);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        test_staircase("refill");
    endtask

    task automatic test_random();
        for (int t = 0; t < 300; t++) begin
            enable = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < AS; i++) din[i] = DW'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                hist.delete();
            end else begin
                rst = 1'b1;
            end
            cycle();
            for (int i = 0; i < AS; i++) begin
                nvec++;
                if (dout[i] !== exp_lane(i)) begin
                    nfail++;
                    $display("FAIL random t %0d lane %0d: got %0d expected %0d", t, i, dout[i], exp_lane(i));
                end
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < AS; i++) din[i] = '0;
        #2;
        rst = 1'b0;
        #10;
        test_reset();
        test_staircase("staircase");
        test_streaming();
        test_stall();
        test_signed();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
